// File: rtl/fetch_unit_pkg.sv
// Shared processor constants and the fetch FSM state type.
package fetch_unit_pkg;

  localparam int PC_WIDTH_DEF   = 8;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int RESET_PC_DEF   = 0;

  // Fixed-length instruction words: the sequential PC advances by one word.
  localparam int PC_INCR = 4;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_HOLD = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and decode handshake.
// The master side is the fetch unit; the slave side is memory/decode/PC logic.
interface fetch_unit_if #(
  parameter int PC_WIDTH   = 8,
  parameter int DATA_WIDTH = 32
);

  logic                  imem_req;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic                  imem_ack;
  logic [DATA_WIDTH-1:0] imem_rdata;

  logic                  redirect;
  logic [PC_WIDTH-1:0]   redirect_pc;

  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0]   instr_pc;
  logic                  instr_ready;

  logic [PC_WIDTH-1:0]   pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc,
    input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc,
    output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_REQ  | requesting the word at pc; waiting for imem_ack
//   ST_HOLD | fetched word presented to decode; waiting for instr_ready
//
// A redirect wins over everything except reset: it reloads pc, drops any
// presented or arriving instruction and restarts the request. Memory is
// single-cycle, so moving imem_addr mid-request on a redirect is harmless.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH   = PC_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RESET_PC   = RESET_PC_DEF
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam logic [PC_WIDTH-1:0] PC_RST  = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(PC_INCR);

  fetch_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]   instr_pc_q, instr_pc_d;
  logic                  valid_q, valid_d;
  logic                  transfer;

  // Decode handshake completes only while an instruction is presented.
  assign transfer = valid_q & bus.instr_ready;

  // Next-state and datapath update; redirect applied last so it overrides.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;

    case (state_q)
      ST_REQ: begin
        if (bus.imem_ack) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + PC_STEP;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (transfer) begin
          valid_d = 1'b0;
          state_d = ST_REQ;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_REQ;
      end
    endcase

    if (bus.redirect) begin
      // Arriving data is discarded; the presented word stays on instr as a
      // don't-care since instr_valid drops.
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      pc_d       = bus.redirect_pc;
      valid_d    = 1'b0;
      state_d    = ST_REQ;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_REQ;
      pc_q       <= PC_RST;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  // Outputs: the request address is always the live pc.
  always_comb begin
    bus.imem_req    = (state_q == ST_REQ);
    bus.imem_addr   = pc_q;
    bus.instr_valid = valid_q;
    bus.instr       = instr_q;
    bus.instr_pc    = instr_pc_q;
    bus.pc          = pc_q;
  end

endmodule
